// File: rtl/siu_mon_pkg.sv
// Shared FSM state type, slice width and slice-parity helper for the outbound packet checker.
// Latency: none (declarations only).
// Backpressure: none.
package siu_mon_pkg;

    // Parity is computed over fixed 16-bit slices of the data bus.
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GAP_WAIT = 2'd1,
        ST_PAYLOAD  = 2'd2
    } mon_state_t;

    // Expected parity bit of one slice; odd selects odd parity.
    function automatic logic slice_par(input logic [SLICE_W-1:0] slice, input logic odd);
        return (^slice) ^ odd;
    endfunction

endpackage

// File: rtl/siu_outb_pkt_chk_if.sv
// Outbound header/payload bus observed by the packet checker.
// Latency: none (wires only).
// Backpressure: none; the monitored bus is not flow-controlled.
interface siu_outb_pkt_chk_if
    import siu_mon_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int PAR_W  = DATA_W / SLICE_W
);
    logic              hdr_vld;
    logic              datareq;
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  parity;

    modport master (output hdr_vld, datareq, data, parity);
    modport slave  (input  hdr_vld, datareq, data, parity);
endinterface

// File: rtl/siu_par_chk.sv
// Per-slice parity compare of a data bus against its parity vector.
// Latency: combinational.
// Backpressure: none.
module siu_par_chk
    import siu_mon_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int PAR_ODD = 0,
    localparam int PAR_W  = DATA_W / SLICE_W
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [PAR_W-1:0]  i_parity,
    output logic [PAR_W-1:0]  o_mis
);
    localparam logic ODD = (PAR_ODD != 0);

    // One mismatch bit per slice: set when carried parity disagrees with the data.
    for (genvar g = 0; g < PAR_W; g++) begin : g_slice
        assign o_mis[g] = slice_par(i_data[g*SLICE_W +: SLICE_W], ODD) ^ i_parity[g];
    end

endmodule

// File: rtl/siu_outb_pkt_chk.sv
// Monitors the SIU outbound bus: captures headers, tracks payload beats, flags parity/protocol errors, counts packets.
// Latency: outputs registered, updated one cycle after the observed header/beat.
// Backpressure: none; a passive monitor that freezes entirely while enable is low.
module siu_outb_pkt_chk
    import siu_mon_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int PAR_W   = DATA_W / SLICE_W,
    parameter int BEATS   = 4,
    parameter int GAP     = 1,
    parameter int PAR_ODD = 0
) (
    input  logic              iol2clk,
    input  logic              rst_l,
    input  logic              enable,
    siu_outb_pkt_chk_if.slave bus,
    output logic [DATA_W-1:0] hdr_q,
    output logic              hdr_has_data,
    output logic              pkt_done,
    output logic [31:0]       pkt_cnt,
    output logic [3:0]        beat_idx,
    output logic              err_par,
    output logic              err_proto,
    output logic [3:0]        err_par_beat
);
    localparam logic [3:0] BEAT_LAST = 4'(BEATS - 1);
    localparam logic [1:0] GAP_LAST  = 2'((GAP > 0) ? GAP - 1 : 0);

    mon_state_t        r_state;
    logic [1:0]        r_gap_cnt;
    logic [3:0]        r_beat_idx;
    logic [DATA_W-1:0] r_hdr_q;
    logic              r_hdr_has_data;
    logic              r_pkt_done;
    logic [31:0]       r_pkt_cnt;
    logic              r_err_par;
    logic              r_err_proto;
    logic [3:0]        r_err_par_beat;

    logic [PAR_W-1:0]  w_par_mis;
    logic              w_in_idle;
    logic              w_in_payload;
    logic              w_last_beat;
    logic              w_done_evt;
    logic              w_par_hit;
    logic              w_proto_hit;

    siu_par_chk #(
        .DATA_W  (DATA_W),
        .PAR_ODD (PAR_ODD)
    ) u_par_chk (
        .i_data   (bus.data),
        .i_parity (bus.parity),
        .o_mis    (w_par_mis)
    );

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_payload = (r_state == ST_PAYLOAD);
    assign w_last_beat  = w_in_payload && (r_beat_idx == BEAT_LAST);

    // A packet completes on a header without payload, or on its final beat.
    assign w_done_evt  = enable && ((w_in_idle && bus.hdr_vld && !bus.datareq) || w_last_beat);

    // Only payload beats are parity-checked; header parity is ignored.
    assign w_par_hit   = enable && w_in_payload && (|w_par_mis);

    // A header while a packet is in flight, or a stray datareq without a header.
    assign w_proto_hit = enable && ((!w_in_idle && bus.hdr_vld) ||
                                    (w_in_idle && !bus.hdr_vld && bus.datareq));

    // Packet FSM with header capture, gap/beat counters and the completion pulse.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state        <= ST_IDLE;
            r_gap_cnt      <= 2'd0;
            r_beat_idx     <= 4'd0;
            r_hdr_q        <= '0;
            r_hdr_has_data <= 1'b0;
            r_pkt_done     <= 1'b0;
        end else begin
            r_pkt_done <= w_done_evt;
            if (enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.hdr_vld) begin
                            r_hdr_q        <= bus.data;
                            r_hdr_has_data <= bus.datareq;
                            r_gap_cnt      <= 2'd0;
                            r_beat_idx     <= 4'd0;
                            if (bus.datareq) begin
                                r_state <= (GAP == 0) ? ST_PAYLOAD : ST_GAP_WAIT;
                            end
                        end
                    end
                    ST_GAP_WAIT: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state <= ST_PAYLOAD;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 2'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (r_beat_idx == BEAT_LAST) begin
                            r_state    <= ST_IDLE;
                            r_beat_idx <= 4'd0;
                        end else begin
                            r_beat_idx <= r_beat_idx + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating count of completed packets.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_pkt_cnt <= 32'd0;
        end else if (w_done_evt && (r_pkt_cnt != 32'hFFFF_FFFF)) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
    end

    // Sticky error flags; the first parity error's beat index is kept until reset.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_err_par      <= 1'b0;
            r_err_proto    <= 1'b0;
            r_err_par_beat <= 4'd0;
        end else begin
            if (w_par_hit) begin
                r_err_par <= 1'b1;
                if (!r_err_par) begin
                    r_err_par_beat <= r_beat_idx;
                end
            end
            if (w_proto_hit) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    assign hdr_q        = r_hdr_q;
    assign hdr_has_data = r_hdr_has_data;
    assign pkt_done     = r_pkt_done;
    assign pkt_cnt      = r_pkt_cnt;
    assign beat_idx     = r_beat_idx;
    assign err_par      = r_err_par;
    assign err_proto    = r_err_proto;
    assign err_par_beat = r_err_par_beat;

endmodule

// File: tb/tb_siu_outb_pkt_chk.sv
// Self-checking bench for siu_outb_pkt_chk: directed scenarios plus randomized traffic against a packet-position model.
// Latency: n/a.
// Backpressure: n/a.
module tb_siu_outb_pkt_chk;
    localparam int DATA_W  = 128;
    localparam int PAR_W   = 8;
    localparam int BEATS   = 4;
    localparam int GAP     = 1;
    localparam int PAR_ODD = 0;

    logic        iol2clk = 1'b0;
    logic        rst_l;
    logic        enable;

    logic [DATA_W-1:0] hdr_q;
    logic              hdr_has_data;
    logic              pkt_done;
    logic [31:0]       pkt_cnt;
    logic [3:0]        beat_idx;
    logic              err_par;
    logic              err_proto;
    logic [3:0]        err_par_beat;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: position within a packet, counted in cycles since its header.
    int                m_pos;
    logic [DATA_W-1:0] m_hdr;
    logic              m_has;
    logic              m_done;
    logic [31:0]       m_cnt;
    logic              m_ep;
    logic              m_epr;
    logic [3:0]        m_epb;

    siu_outb_pkt_chk_if #(.DATA_W(DATA_W)) bus ();

    siu_outb_pkt_chk #(
        .DATA_W  (DATA_W),
        .PAR_W   (PAR_W),
        .BEATS   (BEATS),
        .GAP     (GAP),
        .PAR_ODD (PAR_ODD)
    ) dut (
        .iol2clk      (iol2clk),
        .rst_l        (rst_l),
        .enable       (enable),
        .bus          (bus),
        .hdr_q        (hdr_q),
        .hdr_has_data (hdr_has_data),
        .pkt_done     (pkt_done),
        .pkt_cnt      (pkt_cnt),
        .beat_idx     (beat_idx),
        .err_par      (err_par),
        .err_proto    (err_proto),
        .err_par_beat (err_par_beat)
    );

    always #5 iol2clk = ~iol2clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PAR_W-1:0] good_par(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        for (int i = 0; i < PAR_W; i++) begin
            p[i] = (($countones(d[i*16 +: 16]) % 2) == 1) ^ (PAR_ODD != 0);
        end
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic m_reset();
        m_pos  = 0;
        m_hdr  = '0;
        m_has  = 1'b0;
        m_done = 1'b0;
        m_cnt  = 32'd0;
        m_ep   = 1'b0;
        m_epr  = 1'b0;
        m_epb  = 4'd0;
    endtask

    task automatic m_step(input logic en, input logic hv, input logic dr,
                          input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] p);
        logic done;
        done = 1'b0;
        if (en) begin
            if (m_pos == 0) begin
                if (hv) begin
                    m_hdr = d;
                    m_has = dr;
                    if (dr) m_pos = 1;
                    else    done  = 1'b1;
                end else if (dr) begin
                    m_epr = 1'b1;
                end
            end else begin
                if (hv) m_epr = 1'b1;
                if (m_pos > GAP && p != good_par(d)) begin
                    if (!m_ep) m_epb = 4'(m_pos - GAP - 1);
                    m_ep = 1'b1;
                end
                m_pos++;
                if (m_pos > GAP + BEATS) begin
                    m_pos = 0;
                    done  = 1'b1;
                end
            end
            if (done && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        m_done = done;
    endtask

    task automatic compare_all();
        logic [3:0] eb;
        eb = (m_pos > GAP) ? 4'(m_pos - GAP - 1) : 4'd0;
        chk("hdr_q",        128'(hdr_q),        128'(m_hdr));
        chk("hdr_has_data", 128'(hdr_has_data), 128'(m_has));
        chk("pkt_done",     128'(pkt_done),     128'(m_done));
        chk("pkt_cnt",      128'(pkt_cnt),      128'(m_cnt));
        chk("beat_idx",     128'(beat_idx),     128'(eb));
        chk("err_par",      128'(err_par),      128'(m_ep));
        chk("err_proto",    128'(err_proto),    128'(m_epr));
        chk("err_par_beat", 128'(err_par_beat), 128'(m_epb));
    endtask

    // One bus cycle: drive at the falling edge, sample just after the rising edge.
    task automatic cyc(input logic en, input logic hv, input logic dr,
                       input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] pflip);
        @(negedge iol2clk);
        enable      = en;
        bus.hdr_vld = hv;
        bus.datareq = dr;
        bus.data    = d;
        bus.parity  = good_par(d) ^ pflip;
        m_step(en, hv, dr, d, bus.parity);
        @(posedge iol2clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        enable      = 1'b0;
        bus.hdr_vld = 1'b0;
        bus.datareq = 1'b0;
        bus.data    = '0;
        bus.parity  = '0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_l = 1'b0;
        m_reset();
        #1;
        compare_all();
        chk({tag, "_cnt"},  128'(pkt_cnt),  128'd0);
        chk({tag, "_hdr"},  128'(hdr_q),    128'd0);
        chk({tag, "_beat"}, 128'(beat_idx), 128'd0);
        @(negedge iol2clk);
        idle_inputs();
        rst_l = 1'b1;
    endtask

    // Full data-carrying packet; bad_a/bad_b pick beats with slice 0 parity flipped, hdr_beat a beat carrying a stray header.
    task automatic pkt(input logic [DATA_W-1:0] h, input int bad_a, input int bad_b, input int hdr_beat);
        cyc(1'b1, 1'b1, 1'b1, h, '0);
        for (int g = 0; g < GAP; g++) cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        for (int b = 0; b < BEATS; b++) begin
            cyc(1'b1, 1'(b == hdr_beat), 1'b0, rnd128(),
                (b == bad_a || b == bad_b) ? 8'h01 : 8'h00);
        end
    endtask

    initial begin
        logic             en, hv, dr;
        logic [PAR_W-1:0] pf;

        rst_l = 1'b1;
        idle_inputs();
        m_reset();
        do_reset("rst0");

        // Header without payload.
        cyc(1'b1, 1'b1, 1'b0, 128'h1234, '0);
        chk("t37_hdr",  128'(hdr_q),    128'h1234);
        chk("t37_done", 128'(pkt_done), 128'd1);
        chk("t37_cnt",  128'(pkt_cnt),  128'd1);
        cyc(1'b0, 1'b0, 1'b0, '0, '0);
        chk("t37_pulse", 128'(pkt_done), 128'd0);

        // Clean data packet, beat index walked beat by beat.
        cyc(1'b1, 1'b1, 1'b1, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        for (int k = 0; k < BEATS; k++) begin
            chk("t38_idx", 128'(beat_idx), 128'(k));
            chk("t38_nodone", 128'(pkt_done), 128'd0);
            cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        end
        chk("t38_done", 128'(pkt_done), 128'd1);
        chk("t38_epar", 128'(err_par),  128'd0);
        chk("t38_cnt",  128'(pkt_cnt),  128'd2);

        // Parity errors on beats 2 and 3; the first one is recorded.
        pkt(rnd128(), 2, 3, -1);
        chk("t39_epar",  128'(err_par),      128'd1);
        chk("t39_ebeat", 128'(err_par_beat), 128'd2);
        chk("t39_cnt",   128'(pkt_cnt),      128'd3);

        // Stray header during beat 1 is flagged but the packet still completes.
        pkt(rnd128(), -1, -1, 1);
        chk("t40_eproto", 128'(err_proto), 128'd1);
        chk("t40_cnt",    128'(pkt_cnt),   128'd4);
        chk("t40_ebeat",  128'(err_par_beat), 128'd2);

        // Enable dropped mid-packet freezes progress.
        cyc(1'b1, 1'b1, 1'b1, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, rnd128(), '0);
            chk("t32_hold", 128'(beat_idx), 128'd1);
        end
        for (int k = 1; k < BEATS; k++) cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        chk("t32_cnt", 128'(pkt_cnt), 128'd5);

        // Reset during beat 2 abandons the packet; the next one is handled normally.
        cyc(1'b1, 1'b1, 1'b1, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        do_reset("t41");
        pkt(128'hABCD, -1, -1, -1);
        chk("t41_cnt", 128'(pkt_cnt), 128'd1);
        chk("t41_hdr", 128'(hdr_q),   128'hABCD);

        // Counter saturation from a preloaded near-full value.
        force dut.r_pkt_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_pkt_cnt;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, rnd128(), '0);
            cyc(1'b1, 1'b0, 1'b0, rnd128(), '0);
        end
        chk("t42_sat", 128'(pkt_cnt), 128'hFFFF_FFFF);

        // Randomized traffic: headers, stray headers/datareq, parity faults, enable gaps.
        do_reset("rst1");
        for (int n = 0; n < 3000; n++) begin
            en = 1'($urandom_range(0, 9) != 0);
            if (m_pos == 0) begin
                hv = 1'($urandom_range(0, 2) == 0);
                dr = hv ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 19) == 0);
            end else begin
                hv = 1'($urandom_range(0, 24) == 0);
                dr = 1'b0;
            end
            pf = ($urandom_range(0, 19) == 0) ? PAR_W'(8'h01 << $urandom_range(0, 7)) : '0;
            if (!en) begin
                hv = 1'b0;
                dr = 1'b0;
                pf = '0;
            end
            cyc(en, hv, dr, rnd128(), pf);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
